// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone initiator: FSM state encoding,
// default bus widths and a ceiling-log2 helper for counter sizing.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam int WB_ADW = 32;
    localparam int WB_DW  = 32;

    // Bits needed to count 0 .. value-1 (never less than one bit).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v / 32'sd2) begin
            width = width + 32'sd1;
        end
        return (width < 32'sd1) ? 32'sd1 : width;
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog for wb_initiator: counts stalled BUS cycles and flags
// the last one allowed before abort (used only with WB_INITIATOR_TIMEOUT_EN).
module wb_timeout
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int            CW   = clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_r;

    // Counter of un-acked bus cycles; clear has priority, saturates at LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && !hit) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // hit marks the TIMEOUT-th cycle of stb, so abort happens at its end.
    assign hit = (count_r == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator bridging a valid/ready
// request/response pair; bus timeout built only with WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int ADW     = WB_ADW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [ADW-1:0]  req_adr,
    input  logic [DW-1:0]   req_dat,
    input  logic [DW/8-1:0] req_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [ADW-1:0]  wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT must be at least 1");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("wb_initiator: DW must be a multiple of 8");
    end

    wb_state_e       state_r,     state_nxt_s;
    logic            bus_r,       bus_nxt_s;
    logic            we_r,        we_nxt_s;
    logic [ADW-1:0]  adr_r,       adr_nxt_s;
    logic [DW-1:0]   dat_r,       dat_nxt_s;
    logic [DW/8-1:0] sel_r,       sel_nxt_s;
    logic            req_ready_r, req_ready_nxt_s;
    logic            rsp_valid_r, rsp_valid_nxt_s;
    logic [DW-1:0]   rsp_dat_r,   rsp_dat_nxt_s;
    logic            rsp_err_r,   rsp_err_nxt_s;
    logic            timeout_hit_s;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic cnt_clr_s;
    logic cnt_en_s;

    assign cnt_clr_s = req_valid && req_ready_r;
    assign cnt_en_s  = (state_r == ST_BUS) && !wbm_ack_i;

    wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (cnt_clr_s),
        .en  (cnt_en_s),
        .hit (timeout_hit_s)
    );
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State and every output register; reset abandons any bus cycle or response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            bus_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= '0;
            dat_r       <= '0;
            sel_r       <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_r       <= bus_nxt_s;
            we_r        <= we_nxt_s;
            adr_r       <= adr_nxt_s;
            dat_r       <= dat_nxt_s;
            sel_r       <= sel_nxt_s;
            req_ready_r <= req_ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_dat_r   <= rsp_dat_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    // Next-state and next-output decode; ack takes priority over timeout.
    always_comb begin
        state_nxt_s     = state_r;
        bus_nxt_s       = bus_r;
        we_nxt_s        = we_r;
        adr_nxt_s       = adr_r;
        dat_nxt_s       = dat_r;
        sel_nxt_s       = sel_r;
        req_ready_nxt_s = req_ready_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_dat_nxt_s   = rsp_dat_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_nxt_s     = ST_BUS;
                    bus_nxt_s       = 1'b1;
                    we_nxt_s        = req_we;
                    adr_nxt_s       = req_adr;
                    dat_nxt_s       = req_dat;
                    sel_nxt_s       = req_sel;
                    req_ready_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i || timeout_hit_s) begin
                    state_nxt_s     = ST_RESP;
                    bus_nxt_s       = 1'b0;
                    we_nxt_s        = 1'b0;
                    adr_nxt_s       = '0;
                    dat_nxt_s       = '0;
                    sel_nxt_s       = '0;
                    rsp_valid_nxt_s = 1'b1;
                    if (wbm_ack_i) begin
                        rsp_dat_nxt_s = we_r ? '0 : wbm_dat_i;
                        rsp_err_nxt_s = 1'b0;
                    end else begin
                        rsp_dat_nxt_s = '0;
                        rsp_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s     = ST_IDLE;
                    req_ready_nxt_s = 1'b1;
                    rsp_valid_nxt_s = 1'b0;
                    rsp_dat_nxt_s   = '0;
                    rsp_err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                bus_nxt_s       = 1'b0;
                we_nxt_s        = 1'b0;
                adr_nxt_s       = '0;
                dat_nxt_s       = '0;
                sel_nxt_s       = '0;
                req_ready_nxt_s = 1'b1;
                rsp_valid_nxt_s = 1'b0;
                rsp_dat_nxt_s   = '0;
                rsp_err_nxt_s   = 1'b0;
            end
        endcase
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;
    assign wbm_cyc_o = bus_r;
    assign wbm_stb_o = bus_r;
    assign wbm_we_o  = we_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign wbm_sel_o = sel_r;

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator against a transaction-level model of
// bus-cycle length, response data and error; timeout cases need WB_INITIATOR_TIMEOUT_EN.
module tb_wb_initiator;

    localparam int ADW     = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 4;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready, req_we;
    logic [ADW-1:0] req_adr;
    logic [DW-1:0]  req_dat;
    logic [SW-1:0]  req_sel;
    logic           rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]  rsp_dat;
    logic           cyc, stb, we;
    logic [ADW-1:0] adr;
    logic [DW-1:0]  dat_o, dat_i;
    logic [SW-1:0]  sel;
    logic           ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_initiator #(
        .ADW (ADW), .DW (DW), .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),       .wb_rst_i  (rst),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_we    (req_we),    .req_adr   (req_adr),
        .req_dat   (req_dat),   .req_sel   (req_sel),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),   .rsp_err   (rsp_err),
        .wbm_cyc_o (cyc),       .wbm_stb_o (stb),
        .wbm_we_o  (we),        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),     .wbm_sel_o (sel),
        .wbm_dat_i (dat_i),     .wbm_ack_i (ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // One transaction: responder acks on bus cycle waitc+1, consumer waits rdelay cycles.
    task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                          input logic [3:0] t_sel, input int waitc, input logic [31:0] rdata,
                          input int rdelay);
        int          n;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_dat;
        exp_err = TOUT_EN && (waitc + 1 > TIMEOUT);
        exp_n   = exp_err ? TIMEOUT : waitc + 1;
        exp_dat = (exp_err || t_we) ? 32'h0 : rdata;

        check("idle_req_ready", req_ready, 1'b1);
        check("idle_cyc", cyc, 1'b0);
        check("idle_adr", adr, 32'h0);
        req_valid = 1'b1; req_we = t_we; req_adr = t_adr; req_dat = t_dat; req_sel = t_sel;
        tick;
        n = 0;
        while (n < 300 && stb === 1'b1) begin
            n++;
            check("bus_cyc", cyc, 1'b1);
            check("bus_we", we, t_we);
            check("bus_adr", adr, t_adr);
            check("bus_dat", dat_o, t_dat);
            check("bus_sel", sel, t_sel);
            check("bus_req_ready", req_ready, 1'b0);
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom); req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom);
            ack   = (n == waitc + 1);
            dat_i = ack ? rdata : $urandom;
            tick;
        end
        ack = 1'b0; dat_i = $urandom;
        check("stb_cycles", n, exp_n);

        for (int i = 0; i <= rdelay; i++) begin
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_dat", rsp_dat, exp_dat);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_cyc", cyc, 1'b0);
            check("rsp_req_ready", req_ready, 1'b0);
            req_valid = 1'b1;
            rsp_ready = (i == rdelay);
            ack       = 1'($urandom_range(0, 1));
            tick;
        end
        rsp_ready = 1'b0; req_valid = 1'b0; ack = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_req_ready", req_ready, 1'b1);
        check("post_cyc", cyc, 1'b0);
        check("post_rsp_dat", rsp_dat, 32'h0);
    endtask

    task automatic reset_mid_bus;
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0010; req_dat = 32'h1234_5678; req_sel = 4'hF;
        tick;
        req_valid = 1'b0;
        check("rst_bus1_stb", stb, 1'b1);
        tick;
        check("rst_bus2_stb", stb, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_cyc", cyc, 1'b0);
        check("rst_stb", stb, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_adr", adr, 32'h0);
        ack = 1'b1; dat_i = 32'hFFFF_FFFF;
        tick;
        ack = 1'b0;
        check("late_ack_cyc", cyc, 1'b0);
        check("late_ack_rsp_valid", rsp_valid, 1'b0);
        check("late_ack_req_ready", req_ready, 1'b1);
        check("late_ack_rsp_dat", rsp_dat, 32'h0);
    endtask

    // Four reads with req_valid/rsp_ready held high and a zero-wait responder.
    task automatic back_to_back;
        logic [31:0] adrs [4];
        int          issued = 0;
        int          got    = 0;
        int          last_t = 0;
        int          t      = 0;
        logic        accept;
        for (int i = 0; i < 4; i++) adrs[i] = $urandom & 32'hFFFF_FFFC;
        rsp_ready = 1'b1;
        while (got < 4 && t < 60) begin
            req_valid = (issued < 4);
            req_we    = 1'b0;
            req_adr   = adrs[(issued < 4) ? issued : 0];
            req_dat   = $urandom;
            req_sel   = 4'hF;
            ack       = stb;
            dat_i     = rdata_of(adr);
            check("b2b_we", we, 1'b0);
            if (rsp_valid === 1'b1) begin
                check("b2b_dat", rsp_dat, rdata_of(adrs[got]));
                check("b2b_err", rsp_err, 1'b0);
                if (got > 0) check("b2b_interval", t - last_t, 3);
                last_t = t;
                got++;
            end
            accept = req_valid && req_ready;
            tick;
            t++;
            if (accept) issued++;
        end
        check("b2b_count", got, 4);
        req_valid = 1'b0; rsp_ready = 1'b0; ack = 1'b0;
        tick;
        check("b2b_idle_ready", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
        rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_dat", rsp_dat, 32'h0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_cyc", cyc, 1'b0);
        check("reset_stb", stb, 1'b0);
        check("reset_we", we, 1'b0);
        check("reset_sel", sel, 4'h0);
        tick;

        do_txn(1'b1, 32'h3000_0000, 32'h0000_0001, 4'hF, 1, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 0, 32'h0000_0022, 0);
        do_txn(1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 0, 32'hCAFE_0123, 5);
`ifdef WB_INITIATOR_TIMEOUT_EN
        do_txn(1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF, 50, 32'h1111_2222, 0);
        do_txn(1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF, TIMEOUT - 1, 32'h3333_4444, 0);
`endif
        reset_mid_bus;
        back_to_back;

        for (int k = 0; k < 40; k++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                   $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
